// File: rtl/hd_frame_acc.sv
// Purpose: streaming Hamming(7,4)/SECDED(8,4) pair decoder with per-frame weighted accumulation.
// Latency: out_valid pulses 2 clk edges after the edge that samples the frame's last codeword.
// Backpressure: none; in_valid gaps simply stall the pairing FSM and frame counter.
module hd_frame_acc #(
    parameter int  PAIRS  = 4,
    parameter int  SECDED = 0,
    localparam int CW_W   = 7 + ((SECDED != 0) ? 1 : 0),
    localparam int ACC_W  = 6 + $clog2(PAIRS),
    localparam int CNT_W  = $clog2(2 * PAIRS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CW_W-1:0]  code_word,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] corr_cnt,
    output logic             dbl_err
);

    localparam bit SD   = (SECDED != 0);
    localparam int PC_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    // Per-word decode result: corrected data, error-bit selector, status.
    typedef struct packed {
        logic [3:0] c;
        logic       eb;
        logic       corr;
        logic       dbl;
    } dec_t;

    typedef enum logic {
        S_W1,
        S_W2
    } state_t;

    // Syndrome decode of one codeword. Parity bits live at positions 4..6,
    // so a syndrome pointing there leaves the data nibble untouched.
    function automatic dec_t decode(input logic [CW_W-1:0] x);
        dec_t       d;
        logic [2:0] syn;
        logic [2:0] pos;
        logic       p_all;
        syn = {x[6] ^ x[3] ^ x[2] ^ x[1],
               x[5] ^ x[3] ^ x[2] ^ x[0],
               x[4] ^ x[3] ^ x[1] ^ x[0]};
        case (syn)
            3'b110:  pos = 3'd2;
            3'b101:  pos = 3'd1;
            3'b011:  pos = 3'd0;
            3'b111:  pos = 3'd3;
            3'b001:  pos = 3'd4;
            3'b010:  pos = 3'd5;
            default: pos = 3'd6;
        endcase
        d.eb  = x[pos];
        d.c   = x[3:0];
        if ((syn != 3'b000) && (pos < 3'd4)) begin
            d.c[pos[1:0]] = ~x[pos];
        end
        p_all = ^x;
        if (SD) begin
            // Odd overall parity means a single (possibly bit-7) error;
            // a syndrome with even parity means two bits flipped.
            d.corr = p_all;
            d.dbl  = (syn != 3'b000) && !p_all;
        end else begin
            d.corr = (syn != 3'b000);
            d.dbl  = 1'b0;
        end
        return d;
    endfunction

    state_t          state, state_nxt;
    logic [PC_W-1:0] pair_cnt, pair_cnt_nxt;
    logic            pair_done;
    logic            frame_first;
    logic            frame_last;
    logic [CW_W-1:0] w1_dat;
    dec_t            dec1, dec2;

    // Stage 1 registers
    logic            s1_vld;
    logic            s1_first;
    logic            s1_last;
    logic [3:0]      s1_c1, s1_c2;
    logic            s1_eb1, s1_eb2;
    logic [1:0]      s1_corr;
    logic            s1_dbl;

    // Stage 2 registers
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        corr_acc;
    logic                    dbl_acc;
    logic                    s2_last;

    logic signed [5:0] c1e, c2e, term;

    assign dec1 = decode(w1_dat);
    assign dec2 = decode(code_word);

    // Pairing FSM and pair-within-frame counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_W1;
            pair_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pair_cnt <= pair_cnt_nxt;
        end
    end

    // Next-state: advance only on valid words; wrap the pair counter per frame.
    always_comb begin
        state_nxt    = state;
        pair_cnt_nxt = pair_cnt;
        pair_done    = 1'b0;
        frame_first  = (pair_cnt == '0);
        frame_last   = (pair_cnt == PC_W'(PAIRS - 1));
        if (in_valid) begin
            case (state)
                S_W1: begin
                    state_nxt = S_W2;
                end
                S_W2: begin
                    state_nxt    = S_W1;
                    pair_done    = 1'b1;
                    pair_cnt_nxt = frame_last ? '0 : pair_cnt + PC_W'(1);
                end
                default: begin
                    state_nxt = S_W1;
                end
            endcase
        end
    end

    // Hold the first word of a pair until its partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_dat <= '0;
        end else if (in_valid && (state == S_W1)) begin
            w1_dat <= code_word;
        end
    end

    // Stage 1: capture both decode results of the pair just completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_c1    <= '0;
            s1_c2    <= '0;
            s1_eb1   <= 1'b0;
            s1_eb2   <= 1'b0;
            s1_corr  <= '0;
            s1_dbl   <= 1'b0;
        end else begin
            s1_vld <= pair_done;
            if (pair_done) begin
                s1_first <= frame_first;
                s1_last  <= frame_last;
                s1_c1    <= dec1.c;
                s1_c2    <= dec2.c;
                s1_eb1   <= dec1.eb;
                s1_eb2   <= dec2.eb;
                s1_corr  <= {1'b0, dec1.corr} + {1'b0, dec2.corr};
                s1_dbl   <= dec1.dbl | dec2.dbl;
            end
        end
    end

    assign c1e = 6'($signed(s1_c1));
    assign c2e = 6'($signed(s1_c2));

    // Pair term weighted by the two error-bit selectors; uncorrectable pairs add nothing.
    always_comb begin
        term = '0;
        case ({s1_eb1, s1_eb2})
            2'b00:   term = (c1e <<< 1) + c2e;
            2'b01:   term = (c1e <<< 1) - c2e;
            2'b10:   term = c1e - (c2e <<< 1);
            default: term = c1e + (c2e <<< 1);
        endcase
        if (s1_dbl) begin
            term = '0;
        end
    end

    // Stage 2: accumulate; the first pair of a frame reloads instead of adding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            corr_acc <= '0;
            dbl_acc  <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_last <= s1_vld & s1_last;
            if (s1_vld) begin
                acc      <= (s1_first ? ACC_W'(0) : acc) + ACC_W'(term);
                corr_acc <= (s1_first ? CNT_W'(0) : corr_acc) + CNT_W'(s1_corr);
                dbl_acc  <= (s1_first ? 1'b0 : dbl_acc) | s1_dbl;
            end
        end
    end

    // Output register: present the frame result for exactly one cycle, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            corr_cnt  <= '0;
            dbl_err   <= 1'b0;
        end else begin
            out_valid <= s2_last;
            out_sum   <= s2_last ? acc : '0;
            corr_cnt  <= s2_last ? corr_acc : '0;
            dbl_err   <= s2_last & dbl_acc;
        end
    end

endmodule
